// File: rtl/pea_pkg.sv
// Shared types, default widths and the requantization helper for the PE-array output path.
package pea_pkg;

   typedef enum logic [1:0] {
      BS_FREE  = 2'd0,
      BS_ACC   = 2'd1,
      BS_FULL  = 2'd2,
      BS_DRAIN = 2'd3
   } bank_st_t;

   localparam int PEA_COL      = 8;
   localparam int PEA_TILE_LEN = 16;
   localparam int PEA_PSUM_W   = 24;
   localparam int PEA_ACC_W    = 32;
   localparam int PEA_OUT_W    = 8;
   localparam int PEA_SHIFT_W  = 5;

   // Arithmetic shift, optional ReLU, then saturate to a signed out_w-bit range.
   // Caller sign-extends its accumulator to 64 bits and keeps the low out_w bits.
   function automatic logic signed [63:0] pea_requant(
      input logic signed [63:0] acc,
      input int                 shamt,
      input logic               relu,
      input int                 out_w
   );
      logic signed [63:0] v;
      logic signed [63:0] vmax;
      logic signed [63:0] vmin;
      v    = acc >>> shamt;
      vmax = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      vmin = -(64'sd1 <<< (out_w - 1));
      if (relu && v[63]) v = '0;
      if (v > vmax)      v = vmax;
      else if (v < vmin) v = vmin;
      return v;
   endfunction

endpackage

// File: rtl/pea_ofm_bank.sv
// One accumulator bank: TILE_LEN x COL saturating accumulators, per-entry lane mask and tile length.
// Writes land on the clock edge; the read port is combinational.
module pea_ofm_bank #(
   parameter int COL      = 8,
   parameter int TILE_LEN = 16,
   parameter int PSUM_W   = 24,
   parameter int ACC_W    = 32,
   parameter int IDX_W    = $clog2(TILE_LEN),
   parameter int LEN_W    = $clog2(TILE_LEN + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic                    i_wr_en,
   input  logic                    i_wr_first,
   input  logic [IDX_W-1:0]        i_wr_idx,
   input  logic [COL-1:0]          i_wr_lanes,
   input  logic [COL*PSUM_W-1:0]   i_wr_psum,
   input  logic                    i_len_we,
   input  logic [LEN_W-1:0]        i_len,
   input  logic [IDX_W-1:0]        i_rd_idx,
   output logic [COL*ACC_W-1:0]    o_rd_acc,
   output logic [COL-1:0]          o_rd_mask,
   output logic [LEN_W-1:0]        o_len
);

   logic [ACC_W-1:0] r_acc  [TILE_LEN][COL];
   logic [COL-1:0]   r_mask [TILE_LEN];
   logic [LEN_W-1:0] r_len;

   logic [ACC_W-1:0] w_sext [COL];
   logic [ACC_W:0]   w_wide [COL];
   logic [ACC_W-1:0] w_sum  [COL];

   // One guard bit catches signed overflow; clamp toward the sign of the true sum.
   always_comb begin
      for (int i = 0; i < COL; i++) begin
         w_sext[i] = {{(ACC_W-PSUM_W){i_wr_psum[i*PSUM_W+PSUM_W-1]}}, i_wr_psum[i*PSUM_W +: PSUM_W]};
         w_wide[i] = {r_acc[i_wr_idx][i][ACC_W-1], r_acc[i_wr_idx][i]} + {w_sext[i][ACC_W-1], w_sext[i]};
         if (w_wide[i][ACC_W] != w_wide[i][ACC_W-1])
            w_sum[i] = w_wide[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         else
            w_sum[i] = w_wide[i][ACC_W-1:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         for (int i = 0; i < COL; i++) begin
            if (i_wr_lanes[i]) r_acc[i_wr_idx][i] <= i_wr_first ? w_sext[i] : w_sum[i];
         end
         if (i_wr_first) r_mask[i_wr_idx] <= i_wr_lanes;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn)       r_len <= '0;
      else if (i_len_we) r_len <= i_len;
   end

   always_comb begin
      for (int i = 0; i < COL; i++) o_rd_acc[i*ACC_W +: ACC_W] = r_acc[i_rd_idx][i];
   end
   assign o_rd_mask = r_mask[i_rd_idx];
   assign o_len     = r_len;

endmodule

// File: rtl/pea_ofm_wb.sv
// Accumulates PE-array partial sums into ping-pong banks and drains requantized tiles to the OFM buffer.
// First entry one cycle after a bank fills; entries held stable while o_ofm_valid && !i_ofm_ready.
module pea_ofm_wb
   import pea_pkg::*;
#(
   parameter int COL      = PEA_COL,
   parameter int TILE_LEN = PEA_TILE_LEN,
   parameter int PSUM_W   = PEA_PSUM_W,
   parameter int ACC_W    = PEA_ACC_W,
   parameter int OUT_W    = PEA_OUT_W,
   parameter int SHIFT_W  = PEA_SHIFT_W
) (
   input  logic                   i_clk,
   input  logic                   i_rstn,
   input  logic [COL-1:0]         i_pvalid,
   input  logic [COL*PSUM_W-1:0]  i_psum,
   input  logic                   i_pass_end,
   input  logic                   i_oc_last_pass,
   input  logic                   i_relu_en,
   input  logic [SHIFT_W-1:0]     i_shift,
   output logic                   o_ofm_valid,
   input  logic                   i_ofm_ready,
   output logic [COL*OUT_W-1:0]   o_ofm_data,
   output logic [COL-1:0]         o_ofm_mask,
   output logic                   o_ofm_last,
   output logic                   o_busy,
   output logic                   o_err_ovf
);

   localparam int IDX_W = $clog2(TILE_LEN);
   localparam int LEN_W = $clog2(TILE_LEN + 1);

   bank_st_t           r_st [2];
   bank_st_t           w_st_nxt [2];
   logic               r_wr_bank;
   logic               r_first_pass;
   logic [IDX_W-1:0]   r_beat_idx;
   logic               r_err_ovf;
   logic               r_drain_ptr;
   logic               r_src_vld;
   logic               r_src_bank;
   logic [IDX_W-1:0]   r_rd_idx;
   logic               r_out_bank;
   logic               r_ofm_valid;
   logic               r_ofm_last;
   logic [COL*OUT_W-1:0] r_ofm_data;
   logic [COL-1:0]     r_ofm_mask;

   logic               w_beat, w_accept, w_close, w_hs, w_can_load, w_start, w_load, w_load_last;
   logic               w_rd_bank;
   logic [IDX_W-1:0]   w_rd_idx;
   logic [COL*ACC_W-1:0] w_rd_acc_b [2];
   logic [COL-1:0]     w_rd_mask_b [2];
   logic [LEN_W-1:0]   w_len [2];
   logic [COL*ACC_W-1:0] w_rd_acc;
   logic [COL-1:0]     w_rd_mask;
   logic [COL*OUT_W-1:0] w_rq;

   assign w_beat     = |i_pvalid;
   assign w_accept   = w_beat && (r_st[r_wr_bank] == BS_FREE || r_st[r_wr_bank] == BS_ACC);
   assign w_close    = w_accept && i_pass_end && i_oc_last_pass;
   assign w_hs       = r_ofm_valid && i_ofm_ready;
   assign w_can_load = !r_ofm_valid || i_ofm_ready;
   // A new bank may start loading while the previous one still owns the output register.
   assign w_start    = !r_src_vld && w_can_load && (r_st[r_drain_ptr] == BS_FULL);
   assign w_load     = w_can_load && (r_src_vld || w_start);
   assign w_rd_bank  = r_src_vld ? r_src_bank : r_drain_ptr;
   assign w_rd_idx   = r_src_vld ? r_rd_idx : '0;
   assign w_load_last = (LEN_W'(w_rd_idx) + LEN_W'(1)) == w_len[w_rd_bank];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      pea_ofm_bank #(
         .COL(COL), .TILE_LEN(TILE_LEN), .PSUM_W(PSUM_W), .ACC_W(ACC_W),
         .IDX_W(IDX_W), .LEN_W(LEN_W)
      ) u_bank (
         .i_clk      (i_clk),
         .i_rstn     (i_rstn),
         .i_wr_en    (w_accept && (r_wr_bank == 1'(b))),
         .i_wr_first (r_first_pass),
         .i_wr_idx   (r_beat_idx),
         .i_wr_lanes (i_pvalid),
         .i_wr_psum  (i_psum),
         .i_len_we   (w_accept && i_pass_end && (r_wr_bank == 1'(b))),
         .i_len      (LEN_W'(r_beat_idx) + LEN_W'(1)),
         .i_rd_idx   (w_rd_idx),
         .o_rd_acc   (w_rd_acc_b[b]),
         .o_rd_mask  (w_rd_mask_b[b]),
         .o_len      (w_len[b])
      );
   end

   always_comb begin
      w_rd_acc  = w_rd_acc_b[w_rd_bank];
      w_rd_mask = w_rd_mask_b[w_rd_bank];
      w_rq      = '0;
      for (int i = 0; i < COL; i++) begin
         w_rq[i*OUT_W +: OUT_W] = OUT_W'(pea_requant(
            {{(64-ACC_W){w_rd_acc[i*ACC_W+ACC_W-1]}}, w_rd_acc[i*ACC_W +: ACC_W]},
            int'(i_shift), i_relu_en, OUT_W));
      end
   end

   always_comb begin
      w_st_nxt[0] = r_st[0];
      w_st_nxt[1] = r_st[1];
      if (w_close)
         w_st_nxt[r_wr_bank] = BS_FULL;
      else if (w_accept && r_st[r_wr_bank] == BS_FREE)
         w_st_nxt[r_wr_bank] = BS_ACC;
      if (w_start)
         w_st_nxt[r_drain_ptr] = BS_DRAIN;
      if (w_hs && r_ofm_last)
         w_st_nxt[r_out_bank] = BS_FREE;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_st[0] <= BS_FREE;
         r_st[1] <= BS_FREE;
      end else begin
         r_st[0] <= w_st_nxt[0];
         r_st[1] <= w_st_nxt[1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_wr_bank    <= 1'b0;
         r_first_pass <= 1'b1;
         r_beat_idx   <= '0;
         r_err_ovf    <= 1'b0;
         r_drain_ptr  <= 1'b0;
         r_src_vld    <= 1'b0;
         r_src_bank   <= 1'b0;
         r_rd_idx     <= '0;
         r_out_bank   <= 1'b0;
         r_ofm_valid  <= 1'b0;
         r_ofm_last   <= 1'b0;
         r_ofm_data   <= '0;
         r_ofm_mask   <= '0;
      end else begin
         if (w_accept) begin
            if (i_pass_end) begin
               r_beat_idx   <= '0;
               r_first_pass <= i_oc_last_pass;
               if (i_oc_last_pass) r_wr_bank <= ~r_wr_bank;
            end else if (r_beat_idx == IDX_W'(TILE_LEN - 1)) begin
               r_beat_idx <= '0;
               r_err_ovf  <= 1'b1;
            end else begin
               r_beat_idx <= r_beat_idx + 1'b1;
            end
         end else if (w_beat) begin
            r_err_ovf <= 1'b1;
         end

         if (w_hs) r_ofm_valid <= 1'b0;
         if (w_load) begin
            r_ofm_valid <= 1'b1;
            r_ofm_data  <= w_rq;
            r_ofm_mask  <= w_rd_mask;
            r_ofm_last  <= w_load_last;
            r_out_bank  <= w_rd_bank;
            r_src_vld   <= !w_load_last;
            r_src_bank  <= w_rd_bank;
            r_rd_idx    <= w_rd_idx + 1'b1;
            if (w_start) r_drain_ptr <= ~r_drain_ptr;
         end
      end
   end

   assign o_ofm_valid = r_ofm_valid;
   assign o_ofm_data  = r_ofm_data;
   assign o_ofm_mask  = r_ofm_mask;
   assign o_ofm_last  = r_ofm_last;
   assign o_err_ovf   = r_err_ovf;
   assign o_busy      = (r_st[0] != BS_FREE) || (r_st[1] != BS_FREE);

endmodule

// File: tb/tb_pea_ofm_wb.sv
// Directed bench for pea_ofm_wb: a reference model fills a scoreboard, a negedge monitor checks every drained entry.
module tb_pea_ofm_wb;

   localparam longint AMAX = 64'sd2147483647;
   localparam longint AMIN = -64'sd2147483648;

   typedef struct {
      logic [63:0] data;
      logic [63:0] lm;
      logic [7:0]  mask;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  pvalid;
   logic [191:0] psum;
   logic        pass_end;
   logic        oc_last_pass;
   logic        relu_en;
   logic [4:0]  shift;
   logic        ofm_valid;
   logic        ofm_ready;
   logic [63:0] ofm_data;
   logic [7:0]  ofm_mask;
   logic        ofm_last;
   logic        busy;
   logic        err_ovf;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   longint      macc [16][8];
   logic [7:0]  mmask [16];
   bit          m_first = 1'b1;

   always #5 clk = ~clk;

   pea_ofm_wb dut (
      .i_clk(clk), .i_rstn(rstn), .i_pvalid(pvalid), .i_psum(psum),
      .i_pass_end(pass_end), .i_oc_last_pass(oc_last_pass), .i_relu_en(relu_en),
      .i_shift(shift), .o_ofm_valid(ofm_valid), .i_ofm_ready(ofm_ready),
      .o_ofm_data(ofm_data), .o_ofm_mask(ofm_mask), .o_ofm_last(ofm_last),
      .o_busy(busy), .o_err_ovf(err_ovf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint sat32(input longint v);
      if (v > AMAX) return AMAX;
      if (v < AMIN) return AMIN;
      return v;
   endfunction

   function automatic logic [7:0] rq(input longint acc, input int sh, input bit relu);
      longint v;
      v = acc >>> sh;
      if (relu && v < 0) v = 0;
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
      return v[7:0];
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_tile(input int nb);
      exp_t e;
      for (int b = 0; b < nb; b++) begin
         e.data = '0;
         e.lm   = '0;
         e.mask = mmask[b];
         e.last = (b == nb - 1);
         for (int i = 0; i < 8; i++) begin
            e.data[i*8 +: 8] = rq(macc[b][i], int'(shift), relu_en);
            e.lm[i*8 +: 8]   = {8{mmask[b][i]}};
         end
         sb.push_back(e);
      end
   endtask

   // Lane i carries base + i*stp on every beat; drop=1 means the DUT is expected to discard it.
   task automatic send_pass(input int nb, input logic [7:0] pv, input int base, input int stp,
                            input bit last, input bit drop);
      for (int b = 0; b < nb; b++) begin
         pvalid       = pv;
         pass_end     = (b == nb - 1);
         oc_last_pass = last;
         for (int i = 0; i < 8; i++) begin
            psum[i*24 +: 24] = 24'(base + i * stp);
            if (!drop && pv[i])
               macc[b][i] = m_first ? longint'(base + i * stp) : sat32(macc[b][i] + longint'(base + i * stp));
         end
         if (!drop && m_first) mmask[b] = pv;
         step(1);
      end
      pvalid       = '0;
      pass_end     = 1'b0;
      oc_last_pass = 1'b0;
      if (!drop) begin
         if (last) begin
            push_tile(nb);
            m_first = 1'b1;
         end else begin
            m_first = 1'b0;
         end
      end
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 400) begin
         step(1);
         n++;
      end
      chk(tag, 64'(n < 400), 64'd1);
   endtask

   always @(negedge clk) begin
      if (rstn && ofm_valid && ofm_ready) begin
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("ofm_mask", 64'(ofm_mask), 64'(mon_e.mask));
            chk("ofm_last", 64'(ofm_last), 64'(mon_e.last));
            chk("ofm_data", ofm_data & mon_e.lm, mon_e.data & mon_e.lm);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 1'b0; pvalid = '0; psum = '0; pass_end = 1'b0; oc_last_pass = 1'b0;
      relu_en = 1'b0; shift = '0; ofm_ready = 1'b0;
      step(3);
      chk("rst_valid", 64'(ofm_valid), 64'd0);
      chk("rst_data",  ofm_data, 64'd0);
      chk("rst_mask",  64'(ofm_mask), 64'd0);
      chk("rst_last",  64'(ofm_last), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_err",   64'(err_ovf), 64'd0);
      rstn = 1'b1;
      step(1);

      // full 16-beat tile, one pass, lanes 10..17
      ofm_ready = 1'b1;
      send_pass(16, 8'hFF, 10, 1, 1'b1, 1'b0);
      chk("t1_lat0", 64'(ofm_valid), 64'd0);
      step(1);
      chk("t1_lat1", 64'(ofm_valid), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      wait_drain("t1_drain");

      // three accumulating passes, shift 2
      shift = 5'd2;
      send_pass(4, 8'hFF, 100, 0, 1'b0, 1'b0);
      step(2);
      chk("t2_noval1", 64'(ofm_valid), 64'd0);
      send_pass(4, 8'hFF, 100, 0, 1'b0, 1'b0);
      step(2);
      chk("t2_noval2", 64'(ofm_valid), 64'd0);
      send_pass(4, 8'hFF, 100, 0, 1'b1, 1'b0);
      wait_drain("t2_drain");

      // relu and output saturation
      shift = 5'd0; relu_en = 1'b1;
      send_pass(2, 8'hFF, -300, 0, 1'b1, 1'b0);
      wait_drain("t3_relu");
      relu_en = 1'b0;
      send_pass(2, 8'hFF, -300, 0, 1'b1, 1'b0);
      wait_drain("t3_negsat");
      send_pass(2, 8'hFF, 1000, 0, 1'b1, 1'b0);
      wait_drain("t3_possat");

      // short tile, partial lanes
      send_pass(5, 8'h0F, 3, 5, 1'b1, 1'b0);
      wait_drain("t4_short");

      // accumulator saturation at the signed 32-bit limit
      shift = 5'd24;
      for (int p = 0; p < 260; p++) send_pass(1, 8'hFF, 8388607, 0, (p == 259), 1'b0);
      wait_drain("acc_sat");
      shift = 5'd0;

      // backpressure: both banks occupied, third oc dropped
      ofm_ready = 1'b0;
      send_pass(4, 8'hFF, 20, 1, 1'b1, 1'b0);
      step(1);
      chk("t5_valid", 64'(ofm_valid), 64'd1);
      send_pass(4, 8'hFF, -50, 3, 1'b1, 1'b0);
      step(2);
      chk("t5_stable", ofm_data, sb[0].data);
      chk("t5_busy", 64'(busy), 64'd1);
      chk("t5_err_pre", 64'(err_ovf), 64'd0);
      send_pass(2, 8'hFF, 7, 0, 1'b1, 1'b1);
      chk("t5_err", 64'(err_ovf), 64'd1);
      chk("t5_stable2", ofm_data, sb[0].data);
      ofm_ready = 1'b1;
      wait_drain("t5_drain");

      // reset in the middle of a drain
      send_pass(16, 8'hFF, 1, 1, 1'b1, 1'b0);
      step(4);
      rstn = 1'b0;
      step(1);
      chk("t6_valid", 64'(ofm_valid), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_err", 64'(err_ovf), 64'd0);
      sb.delete();
      rstn = 1'b1;
      step(1);
      send_pass(3, 8'hF0, -7, 2, 1'b1, 1'b0);
      wait_drain("t6_fresh");

      // beat index wrap without pass_end
      pvalid = 8'hFF;
      psum   = '0;
      step(15);
      chk("wrap_pre", 64'(err_ovf), 64'd0);
      step(1);
      pvalid = '0;
      chk("wrap_err", 64'(err_ovf), 64'd1);
      rstn = 1'b0;
      step(1);
      rstn = 1'b1;
      step(1);
      chk("wrap_rst_busy", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
